coarse_multi_capture: RTL

COARSE_MULTI_CAPTURE -- requirements
Module: coarse_multi_capture

---
 rtl/coarse_multi_capture.sv | 131 +++++++++++++
 1 files changed

// File: rtl/coarse_multi_capture.sv
// coarse_multi_capture
//   Free-running coarse counter {epoch, count} sampled into one slot per
//   channel on iStore, then drained through a single registered output word
//   chosen by round-robin arbitration.
// Ports
//   clk, iRst     : clock, async active-high reset
//   iCE, iClr     : count enable; sync clear of count, epoch and loss flags
//   iStore[N_CH]  : per-channel capture request (level-sampled)
//   iReady        : downstream accepts current word
//   oValid/oData/oCh : registered output word {epoch,count} and its channel
//   oLost[N_CH]   : sticky flags, a capture arrived while the slot was full

// One capture slot: holds a timestamp until the arbiter takes it.
module coarse_multi_capture_slot #(
  parameter int D_W = 16
) (
  input  logic           clk,
  input  logic           iRst,
  input  logic           iClr,
  input  logic           store,
  input  logic           take,
  input  logic [D_W-1:0] stamp,
  output logic           pend,
  output logic [D_W-1:0] data,
  output logic           lost
);
  // A slot being drained this edge is free to accept the new capture.
  logic accept;
  assign accept = store && (!pend || take);

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      pend <= 1'b0;
      data <= '0;
      lost <= 1'b0;
    end else begin
      pend <= accept || (pend && !take);
      if (accept) data <= stamp;
      if (iClr)                       lost <= 1'b0;
      else if (store && pend && !take) lost <= 1'b1;
    end
  end
endmodule

module coarse_multi_capture #(
  parameter  int C_DIG = 10,
  parameter  int E_DIG = 6,
  parameter  int N_CH  = 4,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int D_W   = E_DIG + C_DIG
) (
  input  logic            clk,
  input  logic            iRst,
  input  logic            iCE,
  input  logic            iClr,
  input  logic [N_CH-1:0] iStore,
  input  logic            iReady,
  output logic            oValid,
  output logic [D_W-1:0]  oData,
  output logic [CH_W-1:0] oCh,
  output logic [N_CH-1:0] oLost
);
  logic [D_W-1:0]            stamp;
  logic [N_CH-1:0]           pend;
  logic [N_CH-1:0]           take;
  logic [N_CH-1:0][D_W-1:0]  slotData;
  logic [CH_W-1:0]           ptr;
  logic [CH_W-1:0]           gnt;
  logic                      gntVld;
  logic                      load;

  // Epoch sits above count, so a single increment carries count overflow
  // into the epoch and wraps the whole word silently.
  always_ff @(posedge clk or posedge iRst) begin
    if (iRst)      stamp <= '0;
    else if (iClr) stamp <= '0;
    else if (iCE)  stamp <= stamp + D_W'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : gSlot
    coarse_multi_capture_slot #(.D_W(D_W)) uSlot (
      .clk   (clk),
      .iRst  (iRst),
      .iClr  (iClr),
      .store (iStore[i]),
      .take  (take[i]),
      .stamp (stamp),
      .pend  (pend[i]),
      .data  (slotData[i]),
      .lost  (oLost[i])
    );
  end

  assign load = !oValid || iReady;

  // Round-robin: first pending slot at or after ptr+1, wrapping.
  always_comb begin
    logic [CH_W-1:0] idx;
    gntVld = 1'b0;
    gnt    = '0;
    idx    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = CH_W'((int'(ptr) + k) % N_CH);
      if (!gntVld && pend[idx]) begin
        gntVld = 1'b1;
        gnt    = idx;
      end
    end
  end

  always_comb begin
    take = '0;
    if (load && gntVld) take[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge iRst) begin
    if (iRst) begin
      oValid <= 1'b0;
      oData  <= '0;
      oCh    <= '0;
      ptr    <= CH_W'(N_CH - 1);
    end else if (load) begin
      oValid <= gntVld;
      if (gntVld) begin
        oData <= slotData[gnt];
        oCh   <= gnt;
        ptr   <= gnt;
      end
    end
  end
endmodule
